// File: rtl/gabor_window_gen_if.sv
// Stream bundle for gabor_window_gen: raster pixel input, K*K window output.
// The master modport is taken by the window generator; slave by the surrounding pipeline.
interface gabor_window_gen_if #(
    parameter int PIX_W = 8,
    parameter int OUT_W = 10,
    parameter int K     = 5
);
    // Both streams use valid/ready: a transfer happens on a rising edge where
    // valid && ready; once valid is high the producer holds its payload unchanged until that edge.
    logic                   in_valid;
    logic                   in_ready;
    logic [PIX_W-1:0]       in_pixel;
    logic                   win_valid;
    logic                   win_ready;
    logic [K*K*OUT_W-1:0]   win_pixels;
    logic [15:0]            win_row;
    logic [15:0]            win_col;
    logic                   frame_done;

    modport master (
        input  in_valid, in_pixel, win_ready,
        output in_ready, win_valid, win_pixels, win_row, win_col, frame_done
    );

    modport slave (
        output in_valid, in_pixel, win_ready,
        input  in_ready, win_valid, win_pixels, win_row, win_col, frame_done
    );
endinterface

// File: rtl/gabor_window_gen.sv
// Streaming K x K window generator with K-1 line buffers and a K x K shift window.
// Define GABOR_WIN_PAD_EN for zero-padded "same" output; the default build emits "valid" windows only.
module gabor_window_gen #(
    parameter int PIX_W = 8,
    parameter int OUT_W = 10,
    parameter int K     = 5,
    parameter int IMG_W = 512,
    parameter int IMG_H = 512
) (
    input  logic               clk,
    input  logic               rst,
    gabor_window_gen_if.master bus
);
    localparam int H = (K - 1) / 2;
`ifdef GABOR_WIN_PAD_EN
    localparam int GRID_W  = IMG_W + H;
    localparam int GRID_H  = IMG_H + H;
    localparam int EMIT_AT = H;
`else
    localparam int GRID_W  = IMG_W;
    localparam int GRID_H  = IMG_H;
    localparam int EMIT_AT = K - 1;
`endif
    localparam int CW = (GRID_W > 1) ? $clog2(GRID_W) : 1;

    localparam logic [15:0] IMG_W16     = 16'(IMG_W);
    localparam logic [15:0] IMG_H16     = 16'(IMG_H);
    localparam logic [15:0] GRID_W_LAST = 16'(GRID_W - 1);
    localparam logic [15:0] GRID_H_LAST = 16'(GRID_H - 1);
    localparam logic [15:0] EMIT16      = 16'(EMIT_AT);
    localparam logic [15:0] H16         = 16'(H);

    logic [15:0]          sr, sc;
    logic                 real_pos, out_free, step, emit, last_pos;
    logic [PIX_W-1:0]     pix_in;
    logic [CW-1:0]        col_idx;

    logic [PIX_W-1:0]     line_buf [K-1][GRID_W];
    logic [PIX_W-1:0]     col_in   [K];
    logic [PIX_W-1:0]     win_q    [K][K];
    logic [PIX_W-1:0]     win_d    [K][K];
    logic [K*K*OUT_W-1:0] taps_d;

    logic                 win_valid_q, last_q, done_q;
    logic [K*K*OUT_W-1:0] pixels_q;
    logic [15:0]          row_q, col_q;

    assign bus.win_valid  = win_valid_q;
    assign bus.win_pixels = pixels_q;
    assign bus.win_row    = row_q;
    assign bus.win_col    = col_q;
    assign bus.frame_done = done_q;

    // Positions outside the real image are padding: a zero is consumed without a handshake.
    always_comb begin
        real_pos     = (sr < IMG_H16) && (sc < IMG_W16);
        out_free     = !win_valid_q || bus.win_ready;
        bus.in_ready = !rst && out_free && real_pos;
        step         = !rst && out_free && (!real_pos || bus.in_valid);
        pix_in       = real_pos ? bus.in_pixel : '0;
        emit         = (sr >= EMIT16) && (sc >= EMIT16);
        last_pos     = (sr == GRID_H_LAST) && (sc == GRID_W_LAST);
        col_idx      = sc[CW-1:0];
    end

    // Column entering the window: oldest buffered row on top, incoming pixel at the bottom.
    always_comb begin
        for (int i = 0; i < K - 1; i++) begin
            col_in[i] = line_buf[K-2-i][col_idx];
        end
        col_in[K-1] = pix_in;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) begin
                win_d[i][j] = win_q[i][j+1];
            end
            win_d[i][K-1] = col_in[i];
        end
    end

    // Taps above row 0 or left of column 0 are zeroed; this also hides stale data from a prior frame.
    always_comb begin : tap_mux
        logic live;
        taps_d = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
`ifdef GABOR_WIN_PAD_EN
                live = ({16'd0, sr} + 32'(i) >= 32'(K - 1)) &&
                       ({16'd0, sc} + 32'(j) >= 32'(K - 1));
`else
                live = 1'b1;
`endif
                if (live) begin
                    taps_d[(i * K + j) * OUT_W +: OUT_W] = OUT_W'(win_d[i][j]);
                end
            end
        end
    end

    // Storage carries no reset: anything stale is either masked or never reaches an emitted window.
    always_ff @(posedge clk) begin
        if (step) begin
            line_buf[0][col_idx] <= pix_in;
            for (int k = 1; k < K - 1; k++) begin
                line_buf[k][col_idx] <= line_buf[k-1][col_idx];
            end
            win_q <= win_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr          <= '0;
            sc          <= '0;
            win_valid_q <= 1'b0;
            pixels_q    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= win_valid_q && bus.win_ready && last_q;
            if (step) begin
                if (sc == GRID_W_LAST) begin
                    sc <= '0;
                    sr <= (sr == GRID_H_LAST) ? '0 : sr + 16'd1;
                end else begin
                    sc <= sc + 16'd1;
                end
            end
            if (step && emit) begin
                win_valid_q <= 1'b1;
                pixels_q    <= taps_d;
                row_q       <= sr - H16;
                col_q       <= sc - H16;
                last_q      <= last_pos;
            end else if (bus.win_ready) begin
                win_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_gabor_window_gen.sv
// Bench for gabor_window_gen (K=3, 4x4 image); follows GABOR_WIN_PAD_EN to pick padded or valid mode.
`timescale 1ns/1ps
module tb_gabor_window_gen;
    localparam int PIX_W = 8;
    localparam int OUT_W = 10;
    localparam int K     = 3;
    localparam int H     = (K - 1) / 2;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int KK    = K * K;
    localparam int EW    = 32 + KK * OUT_W;
    localparam int NF_MAX  = 2;
    localparam int CYC_MAX = 2000;
`ifdef GABOR_WIN_PAD_EN
    localparam int R0 = 0, R1 = IMG_H - 1, C0 = 0, C1 = IMG_W - 1;
    localparam int FIRST_PIX = H * IMG_W + H;
`else
    localparam int R0 = H, R1 = IMG_H - 1 - H, C0 = H, C1 = IMG_W - 1 - H;
    localparam int FIRST_PIX = (K - 1) * IMG_W + (K - 1);
`endif
    localparam int WPF = (R1 - R0 + 1) * (C1 - C0 + 1);

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gabor_window_gen_if #(.PIX_W(PIX_W), .OUT_W(OUT_W), .K(K)) bus ();

    gabor_window_gen #(
        .PIX_W(PIX_W), .OUT_W(OUT_W), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;

    logic [PIX_W-1:0] img [NF_MAX][IMG_H][IMG_W];
    logic [EW-1:0]    exp_q[$];

    // monitor state
    logic          mon_seq = 1'b0;
    logic          prev_stall = 1'b0;
    logic          prev_final_hs = 1'b0;
    logic [EW-1:0] prev_out = '0;
    logic [EW-1:0] first_got = '0;
    logic [EW-1:0] last_got = '0;
    int            win_cnt = 0;
    int            hs_cnt = 0;
    int            done_cnt = 0;
    int            first_valid_cyc = -1;
    int            first_acc_cyc = -1;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [EW-1:0] pack_win(input int row, input int col, input int t[KK]);
        logic [KK*OUT_W-1:0] p;
        p = '0;
        for (int k = 0; k < KK; k++) p[k*OUT_W +: OUT_W] = OUT_W'(t[k]);
        return {16'(row), 16'(col), p};
    endfunction

    // reference model: every window centre of every frame, taps read straight from the image
    task automatic build_expected(input int nf);
        int t[KK];
        int rr, cc;
        for (int f = 0; f < nf; f++)
            for (int r = R0; r <= R1; r++)
                for (int c = C0; c <= C1; c++) begin
                    for (int i = 0; i < K; i++)
                        for (int j = 0; j < K; j++) begin
                            rr = r + i - H;
                            cc = c + j - H;
                            if (rr >= 0 && rr < IMG_H && cc >= 0 && cc < IMG_W)
                                t[i*K+j] = int'(img[f][rr][cc]);
                            else
                                t[i*K+j] = 0;
                        end
                    exp_q.push_back(pack_win(r, c, t));
                end
    endtask

    // scoreboard / protocol monitor, sampled on the falling edge
    always @(negedge clk) begin
        logic [EW-1:0] cur;
        logic [EW-1:0] expv;
        cur = {bus.win_row, bus.win_col, bus.win_pixels};
        if (rst) begin
            prev_stall    = 1'b0;
            prev_final_hs = 1'b0;
            win_cnt       = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", bus.win_valid, 1);
                check("hold_data", cur, prev_out);
            end
            check("frame_done_timing", bus.frame_done, prev_final_hs);
            if (bus.frame_done) done_cnt++;
            if (bus.win_valid && !bus.win_ready) check("stall_in_ready", bus.in_ready, 0);
            if (bus.win_valid && first_valid_cyc < 0) first_valid_cyc = cyc_cnt;
            prev_final_hs = 1'b0;
            if (bus.win_valid && bus.win_ready) begin
                hs_cnt++;
                if (mon_seq) begin
                    if (win_cnt == 0) first_got = cur;
                    last_got = cur;
                    n_assert++;
                    assert (exp_q.size() > 0) else begin
                        n_fail++;
                        $error("FAIL extra_window: observed %0h expected none", cur);
                    end
                    if (exp_q.size() > 0) begin
                        expv = exp_q.pop_front();
                        check("window_seq", cur, expv);
                    end
                end
                win_cnt++;
                if (win_cnt == WPF) begin
                    prev_final_hs = 1'b1;
                    win_cnt = 0;
                end
            end
            prev_stall = bus.win_valid && !bus.win_ready;
            prev_out   = cur;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_win_valid"},  bus.win_valid, 0);
        check({tag, "_in_ready"},   bus.in_ready, 0);
        check({tag, "_win_pixels"}, bus.win_pixels, 0);
        check({tag, "_win_row"},    bus.win_row, 0);
        check({tag, "_win_col"},    bus.win_col, 0);
        check({tag, "_frame_done"}, bus.frame_done, 0);
    endtask

    // vmode/rmode: 0 continuous, 1 toggle / 5-cycle stall, 2 random
    task automatic run_frames(input int nf, input int vmode, input int rmode);
        int  idx = 0;
        int  total = nf * IMG_W * IMG_H;
        int  cyc = 0;
        int  stall_left = 0;
        bit  stalled = 0;
        bit  v, acc;
        exp_q.delete();
        build_expected(nf);
        hs_cnt = 0;
        done_cnt = 0;
        first_valid_cyc = -1;
        first_acc_cyc = -1;
        mon_seq = 1'b1;
        while ((idx < total || exp_q.size() > 0 || done_cnt < nf) && cyc < CYC_MAX) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            bus.in_valid = (idx < total) && v;
            if (bus.in_valid)
                bus.in_pixel = img[idx / (IMG_W * IMG_H)][(idx / IMG_W) % IMG_H][idx % IMG_W];
            else
                bus.in_pixel = PIX_W'($urandom);
            case (rmode)
                0: bus.win_ready = 1'b1;
                1: begin
                    if (!stalled && bus.win_valid) begin
                        stalled = 1;
                        stall_left = 5;
                    end
                    bus.win_ready = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                end
                default: bus.win_ready = ($urandom_range(0, 1) == 1);
            endcase
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (acc && idx == FIRST_PIX) first_acc_cyc = cyc_cnt;
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        check("frame_timeout", cyc < CYC_MAX, 1);
        check("pixels_accepted", idx, total);
        check("leftover_windows", exp_q.size(), 0);
        check("window_count", hs_cnt, nf * WPF);
        check("frame_done_count", done_cnt, nf);
        bus.in_valid  = 1'b0;
        bus.win_ready = 1'b1;
        mon_seq = 1'b0;
    endtask

    task automatic send_partial_then_reset(input int n);
        int idx = 0;
        int cyc = 0;
        bit acc;
        while (idx < n && cyc < 200) begin
            bus.in_valid  = 1'b1;
            bus.in_pixel  = img[0][idx / IMG_W][idx % IMG_W];
            bus.win_ready = 1'b1;
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        check("partial_accepted", idx, n);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("midrst");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic fill_pattern();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) begin
                img[0][r][c] = PIX_W'(4 * r + c + 1);
                img[1][r][c] = PIX_W'(100 + 4 * r + c);
            end
    endtask

    task automatic fill_random();
        for (int f = 0; f < NF_MAX; f++)
            for (int r = 0; r < IMG_H; r++)
                for (int c = 0; c < IMG_W; c++)
                    img[f][r][c] = PIX_W'($urandom_range(0, 255));
    endtask

    initial begin
        int lit[KK];
        bus.in_valid  = 1'b0;
        bus.in_pixel  = '0;
        bus.win_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        fill_pattern();

        // continuous single frame
        run_frames(1, 0, 0);
        check("first_window_latency", first_valid_cyc, first_acc_cyc + 1);
`ifdef GABOR_WIN_PAD_EN
        lit = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
        check("first_window", first_got, pack_win(0, 0, lit));
        lit = '{11, 12, 0, 15, 16, 0, 0, 0, 0};
        check("last_window", last_got, pack_win(3, 3, lit));
`else
        lit = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        check("first_window", first_got, pack_win(1, 1, lit));
        lit = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
        check("last_window", last_got, pack_win(2, 2, lit));
`endif

        // five-cycle output stall after first window
        run_frames(1, 0, 1);

        // in_valid toggling every other cycle
        run_frames(1, 1, 0);

        // reset after 7 accepted pixels, then a clean frame
        send_partial_then_reset(7);
        run_frames(1, 0, 0);
`ifdef GABOR_WIN_PAD_EN
        lit = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
        check("post_reset_first_window", first_got, pack_win(0, 0, lit));
`else
        lit = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        check("post_reset_first_window", first_got, pack_win(1, 1, lit));
`endif

        // back-to-back frames; first_got ends up holding frame 2's first window
        run_frames(2, 0, 0);
`ifdef GABOR_WIN_PAD_EN
        lit = '{0, 0, 0, 0, 100, 101, 0, 104, 105};
        check("frame2_first_window", first_got, pack_win(0, 0, lit));
`else
        lit = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
        check("frame2_first_window", first_got, pack_win(1, 1, lit));
`endif

        // random images with random valid/ready
        for (int rep = 0; rep < 3; rep++) begin
            fill_random();
            run_frames(2, 2, 2);
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
